// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage and IF/ID pipeline register for a MIPS-style core.
// Owns the PC, issues one instruction-memory request at a time, hands the
// returned word plus its PC+4 to decode, and applies branch/jump redirects
// computed in decode while preserving the architectural delay slot.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous reset, active low (0 = reset)
//   stall       hazard unit: hold PC and IF/ID register
//   pcsrc       decode: conditional branch taken (wins over jump)
//   pcbranch    decode: branch target
//   jump        decode: unconditional jump
//   pcjump      decode: jump target
//   imem_req    instruction memory request
//   imem_addr   fetch address, always word aligned (equals pc)
//   imem_rdata  instruction word, valid while imem_ack=1
//   imem_ack    memory completes the request this cycle
//   id_instr    IF/ID instruction (NOP_INSTR for a bubble)
//   id_pcplus4  IF/ID PC+4 of id_instr
//   id_valid    IF/ID holds a real instruction
//   fetch_busy  request outstanding and not yet acked
//   state_dbg   current fetch FSM state (0 = FETCH, 1 = HOLD)
//
// Memory handshake: a transfer happens in any cycle where imem_req=1 and
// imem_ack=1; ack may arrive in the same cycle as req (zero wait). Once req
// is raised, imem_addr stays stable until that transfer, and at most one
// request is ever outstanding. The memory must drop any in-flight response
// when rst is asserted.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic [31:0] pcbranch,
  input  logic        jump,
  input  logic [31:0] pcjump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] id_instr,
  output logic [31:0] id_pcplus4,
  output logic        id_valid,
  output logic        fetch_busy,
  output logic        state_dbg
);

  // FETCH: a request is on the bus.
  // HOLD : the word came back during a stall and sits in hold_buf.
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] id_instr_nxt;
  logic [31:0] id_pcplus4_nxt;
  logic        id_valid_nxt;
  logic        redir_pending, redir_pending_nxt;
  logic [31:0] redir_target, redir_target_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        acc;
  logic        deliver;
  logic [31:0] deliver_word;

  assign pc_plus4 = pc + 32'd4;

  // pcsrc has priority; targets are forced to word alignment so pc[1:0]
  // can never become nonzero.
  assign target = (pcsrc ? pcbranch : pcjump) & ALIGN_MASK;

  // A redirect is only meaningful when the branch/jump really sits in ID
  // and decode is advancing this cycle.
  assign acc = (pcsrc | jump) & id_valid & ~stall;

  assign imem_req   = rst & (state == FETCH);
  assign imem_addr  = pc;
  assign fetch_busy = imem_req & ~imem_ack;
  assign state_dbg  = state;

  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    id_instr_nxt      = id_instr;
    id_pcplus4_nxt    = id_pcplus4;
    id_valid_nxt      = id_valid;
    redir_pending_nxt = redir_pending;
    redir_target_nxt  = redir_target;
    hold_buf_nxt      = hold_buf;
    deliver           = 1'b0;
    deliver_word      = hold_buf;

    case (state)
      FETCH: begin
        if (imem_ack) begin
          if (!stall) begin
            deliver      = 1'b1;
            deliver_word = imem_rdata;
          end else begin
            // Decode cannot take it yet: park the word and stop requesting
            // so nothing is refetched or lost.
            hold_buf_nxt = imem_rdata;
            state_nxt    = HOLD;
          end
        end else if (!stall) begin
          // Memory still busy: decode advances into a bubble. A branch
          // leaving ID now is remembered until its delay slot arrives.
          id_valid_nxt = 1'b0;
          id_instr_nxt = NOP_INSTR;
          if (acc) begin
            redir_pending_nxt = 1'b1;
            redir_target_nxt  = target;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          deliver      = 1'b1;
          deliver_word = hold_buf;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase

    // The delivered word is the delay slot of whatever branch is in ID, so
    // a redirect only steers the fetch that follows it.
    if (deliver) begin
      id_instr_nxt      = deliver_word;
      id_pcplus4_nxt    = pc_plus4;
      id_valid_nxt      = 1'b1;
      redir_pending_nxt = 1'b0;
      state_nxt         = FETCH;
      if (acc) begin
        pc_nxt = target;
      end else if (redir_pending) begin
        pc_nxt = redir_target;
      end else begin
        pc_nxt = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= FETCH;
      pc            <= RESET_PC & ALIGN_MASK;
      id_instr      <= NOP_INSTR;
      id_pcplus4    <= 32'd0;
      id_valid      <= 1'b0;
      redir_pending <= 1'b0;
      redir_target  <= 32'd0;
      hold_buf      <= 32'd0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      id_instr      <= id_instr_nxt;
      id_pcplus4    <= id_pcplus4_nxt;
      id_valid      <= id_valid_nxt;
      redir_pending <= redir_pending_nxt;
      redir_target  <= redir_target_nxt;
      hold_buf      <= hold_buf_nxt;
    end
  end

endmodule
